// File: rtl/branch_predictor_pkg.sv
// Shared types and 2-bit counter encodings for the fetch-side branch predictor.
package branch_predictor_pkg;

    localparam logic [1:0] SN = 2'b00;
    localparam logic [1:0] WN = 2'b01;
    localparam logic [1:0] WT = 2'b10;
    localparam logic [1:0] ST = 2'b11;

    // Tag is carried at its widest (pc[31:2]); narrower BTBs zero-extend it.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:2] target;
        logic        is_jump;
    } btb_entry_t;

    typedef struct packed {
        logic [31:2] pc;
        logic        is_br;
        logic        is_jump;
        logic        taken;
        logic [31:2] target;
        logic        mispredict;
    } bp_update_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken) return (c == ST) ? ST : c + 2'd1;
        else       return (c == SN) ? SN : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: combinational read port, registered write port.
module branch_predictor_btb
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] rd_pc,
    output btb_entry_t  rd_entry,
    input  logic        wr_en,
    input  logic [31:2] wr_pc,
    input  logic [31:2] wr_target,
    input  logic        wr_is_jump
);

    localparam int unsigned N     = 1 << IDX_BITS;
    localparam int unsigned TAG_W = 30 - IDX_BITS;

    logic [N-1:0]       valid_q;
    logic [TAG_W-1:0]   tag_q     [N];
    logic [31:2]        target_q  [N];
    logic               is_jump_q [N];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;

    assign rd_idx = rd_pc[IDX_BITS+1:2];
    assign wr_idx = wr_pc[IDX_BITS+1:2];

    always_comb begin
        rd_entry         = '0;
        rd_entry.valid   = valid_q[rd_idx];
        rd_entry.tag     = 30'(tag_q[rd_idx]);
        rd_entry.target  = target_q[rd_idx];
        rd_entry.is_jump = is_jump_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_q[wr_idx]     <= wr_pc[31:IDX_BITS+2];
            target_q[wr_idx]  <= wr_target;
            is_jump_q[wr_idx] <= wr_is_jump;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side predictor: BTB + PHT of 2-bit counters with a two-stage update pipe.
// Define BP_GSHARE_EN to XOR a non-speculative global history into the PHT index.
module branch_predictor #(
    parameter int BTB_IDX_BITS = 5,
    parameter int PHT_IDX_BITS = 7,
    parameter int GHR_BITS     = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_br,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] mispredict_cnt
);
    import branch_predictor_pkg::*;

    localparam int unsigned PHT_N = 1 << PHT_IDX_BITS;

    logic [1:0]              pht [PHT_N];
    logic [PHT_IDX_BITS-1:0] rd_idx;
    logic [PHT_IDX_BITS-1:0] wr_idx;

    bp_update_t u1;
    logic       u1_valid;
    btb_entry_t rd_entry;
    logic       hit;
    logic       btb_wr_en;
    logic       unused_bits;

    assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] u1_ghr;

    assign rd_idx = if_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr);
    assign wr_idx = u1.pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(u1_ghr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr    <= '0;
            u1_ghr <= '0;
        end else begin
            u1_ghr <= ghr;
            if (u1_valid && u1.is_br) ghr <= {ghr[GHR_BITS-2:0], u1.taken};
        end
    end
`else
    assign rd_idx = if_pc[PHT_IDX_BITS+1:2];
    assign wr_idx = u1.pc[PHT_IDX_BITS+1:2];
`endif

    branch_predictor_btb #(
        .IDX_BITS(BTB_IDX_BITS)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_pc      (if_pc[31:2]),
        .rd_entry   (rd_entry),
        .wr_en      (btb_wr_en),
        .wr_pc      (u1.pc),
        .wr_target  (u1.target),
        .wr_is_jump (u1.is_jump)
    );

    assign btb_wr_en = u1_valid && (u1.is_jump || (u1.is_br && u1.taken));

    // hit gates everything so untouched tag/target bits never reach the outputs.
    always_comb begin
        hit         = rd_entry.valid && (rd_entry.tag == 30'(if_pc[31:BTB_IDX_BITS+2]));
        pred_taken  = hit && (rd_entry.is_jump || pht[rd_idx][1]);
        pred_target = pred_taken ? {rd_entry.target, 2'b00} : if_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u1_valid       <= 1'b0;
            u1             <= '0;
            mispredict_cnt <= '0;
            for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= WN;
        end else begin
            u1_valid <= upd_valid && (upd_is_br || upd_is_jump);
            if (upd_valid && (upd_is_br || upd_is_jump)) begin
                u1 <= '{pc:         upd_pc[31:2],
                        is_br:      upd_is_br,
                        is_jump:    upd_is_jump,
                        taken:      upd_taken,
                        target:     upd_target[31:2],
                        mispredict: upd_mispredict};
            end
            if (u1_valid) begin
                if (u1.is_br) pht[wr_idx] <= ctr_next(pht[wr_idx], u1.taken);
                if (u1.mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, BP_GSHARE_EN undefined).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_br = 1'b0;
    logic        upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
    logic [31:0] mispredict_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .BTB_IDX_BITS(5),
        .PHT_IDX_BITS(7),
        .GHR_BITS    (7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_br      (upd_is_br),
        .upd_is_jump    (upd_is_jump),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pred(input string tag, input logic [31:0] pc, input logic exp_t,
                        input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        chk({tag, ".taken"}, 32'(pred_taken), 32'(exp_t));
        chk({tag, ".target"}, pred_target, exp_tgt);
    endtask

    // Presents one update for exactly one clock edge.
    task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_br      = br;
        upd_is_jump    = jmp;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mis;
        step();
        upd_valid      = 1'b0;
        upd_is_br      = 1'b0;
        upd_is_jump    = 1'b0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    logic walk_tk  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic walk_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        pred("reset", 32'h60, 1'b0, 32'h64);
        chk("reset.cnt", mispredict_cnt, 32'd0);
        pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // jal at 0x80: invisible while pending in U1, visible after the U2 write
        if_pc = 32'h80;
        upd(32'h80, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
        pred("jal.pending", 32'h80, 1'b0, 32'h84);
        step();
        pred("jal.hit", 32'h80, 1'b1, 32'h200);

        // Counter walk at 0x100: 01->10->11->11->10->01->00->01->10
        for (int i = 0; i < 8; i++) begin
            upd(32'h100, 1'b1, 1'b0, walk_tk[i], 32'h40, 1'b0);
            step();
            pred($sformatf("walk%0d", i), 32'h100, walk_exp[i],
                 walk_exp[i] ? 32'h40 : 32'h104);
        end
        pred("jal.evicted", 32'h80, 1'b0, 32'h84);

        // Aliased BTB index, different tag
        upd(32'h180, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        step();
        pred("alias.old", 32'h100, 1'b0, 32'h104);
        pred("alias.new", 32'h180, 1'b1, 32'h300);

        // Back-to-back updates to one PHT entry: T,T,NT -> 10
        if_pc = 32'h20C;
        upd(32'h20C, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0);
        upd(32'h20C, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0);
        pred("b2b.mid", 32'h20C, 1'b1, 32'h1000);
        upd(32'h20C, 1'b1, 1'b0, 1'b0, 32'h1000, 1'b0);
        step();
        pred("b2b.10", 32'h20C, 1'b1, 32'h1000);
        upd(32'h20C, 1'b1, 1'b0, 1'b0, 32'h1000, 1'b0);
        step();
        pred("b2b.01", 32'h20C, 1'b0, 32'h210);

        // Reset while an update sits in U1
        upd(32'h400, 1'b0, 1'b1, 1'b1, 32'h800, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pred("rstmid.jal", 32'h400, 1'b0, 32'h404);
        chk("rstmid.cnt", mispredict_cnt, 32'd0);
        step();
        pred("rstmid.later", 32'h400, 1'b0, 32'h404);
        pred("rstmid.btb", 32'h180, 1'b0, 32'h184);
        // PHT back to 01: T then NT leaves 01 (not-taken); stale 10 would give taken
        upd(32'h180, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        upd(32'h180, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0);
        step();
        pred("rstmid.pht", 32'h180, 1'b0, 32'h184);

        // Four mispredicted updates, then a typeless update that must be ignored
        upd(32'h500, 1'b1, 1'b0, 1'b0, 32'h900, 1'b1);
        upd(32'h504, 1'b1, 1'b0, 1'b0, 32'h900, 1'b1);
        upd(32'h508, 1'b1, 1'b0, 1'b0, 32'h900, 1'b1);
        upd(32'h50C, 1'b1, 1'b0, 1'b0, 32'h900, 1'b1);
        chk("cnt.mid", mispredict_cnt, 32'd3);
        upd(32'h600, 1'b0, 1'b0, 1'b1, 32'h700, 1'b1);
        chk("cnt.four", mispredict_cnt, 32'd4);
        step();
        chk("cnt.hold", mispredict_cnt, 32'd4);
        pred("typeless", 32'h600, 1'b0, 32'h604);
        pred("nt.nobtb", 32'h500, 1'b0, 32'h504);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
